// File: rtl/puzzle_mode_controller_if.sv
// Signal bundle between the puzzle mode controller and the rest of the game.
// The controller uses the master side; the board logic and the random-move generator use the slave side.
interface puzzle_mode_controller_if #(
  parameter int MOVE_W = 8
);
  logic              scramble_btn;
  logic              rand_ack;
  logic              solved;
  logic              move_valid;
  logic              mix_state;
  logic              rand_req;
  logic              buzz_en;
  logic              scramble_busy;
  logic              win;
  logic [MOVE_W-1:0] move_count;

  modport master (
    input  scramble_btn, rand_ack, solved, move_valid,
    output mix_state, rand_req, buzz_en, scramble_busy, win, move_count
  );

  modport slave (
    output scramble_btn, rand_ack, solved, move_valid,
    input  mix_state, rand_req, buzz_en, scramble_busy, win, move_count
  );
endinterface

// File: rtl/puzzle_mode_controller.sv
// Game sequencer for the scramble/solve puzzle. It cycles through IDLE, SCRAMBLE, SOLVE and WIN,
// requests random moves during SCRAMBLE, counts player moves in SOLVE, and holds the win indication.
module puzzle_mode_controller #(
  parameter int SCRAMBLE_MOVES = 31,
  parameter int WIN_CYCLES     = 100,
  parameter int MOVE_W         = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  puzzle_mode_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCRAMBLE, SOLVE, WIN} stateT;

  localparam int              TIMER_W   = $clog2(WIN_CYCLES + 1);
  localparam logic [TIMER_W-1:0] WIN_LOAD = TIMER_W'(WIN_CYCLES - 1);
  localparam logic [7:0]      MOVES_END = 8'(SCRAMBLE_MOVES);

  stateT                  state;
  logic [SYNC_STAGES-1:0] syncReg;
  logic                   edgeReg;
  logic                   btnEvt;
  logic [7:0]             scrCnt;
  logic [7:0]             scrCntNext;
  logic [TIMER_W-1:0]     winTimer;
  logic [MOVE_W-1:0]      moveCount;
  logic                   randReq;
  logic                   mixState;
  logic                   buzzEn;
  logic                   scrambleBusy;
  logic                   winReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncReg <= '0;
      edgeReg <= 1'b0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], bus.scramble_btn};
      edgeReg <= syncReg[SYNC_STAGES-1];
    end
  end

  // Event is consumed by the FSM on the edge after the last sync stage goes high.
  assign btnEvt     = syncReg[SYNC_STAGES-1] & ~edgeReg;
  assign scrCntNext = scrCnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      scrCnt       <= '0;
      winTimer     <= '0;
      moveCount    <= '0;
      randReq      <= 1'b0;
      mixState     <= 1'b0;
      buzzEn       <= 1'b0;
      scrambleBusy <= 1'b0;
      winReg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btnEvt) begin
            state        <= SCRAMBLE;
            scrCnt       <= '0;
            randReq      <= 1'b1;
            scrambleBusy <= 1'b1;
          end
        end
        SCRAMBLE: begin
          if (randReq && bus.rand_ack) begin
            scrCnt <= scrCntNext;
            if (scrCntNext == MOVES_END) begin
              state        <= SOLVE;
              randReq      <= 1'b0;
              scrambleBusy <= 1'b0;
              mixState     <= 1'b1;
              buzzEn       <= 1'b1;
              moveCount    <= '0;
            end
          end
        end
        SOLVE: begin
          if (bus.move_valid && (moveCount != '1))
            moveCount <= moveCount + MOVE_W'(1);
          // solved has priority over a simultaneous rescramble request
          if (bus.solved) begin
            state    <= WIN;
            winTimer <= WIN_LOAD;
            winReg   <= 1'b1;
            mixState <= 1'b0;
            buzzEn   <= 1'b0;
          end else if (btnEvt) begin
            state        <= SCRAMBLE;
            scrCnt       <= '0;
            randReq      <= 1'b1;
            scrambleBusy <= 1'b1;
            mixState     <= 1'b0;
            buzzEn       <= 1'b0;
          end
        end
        WIN: begin
          if (winTimer == '0) begin
            state  <= IDLE;
            winReg <= 1'b0;
          end else begin
            winTimer <= winTimer - TIMER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rand_req      = randReq;
  assign bus.mix_state     = mixState;
  assign bus.buzz_en       = buzzEn;
  assign bus.scramble_busy = scrambleBusy;
  assign bus.win           = winReg;
  assign bus.move_count    = moveCount;

endmodule

// File: tb/tb_puzzle_mode_controller.sv
// Directed bench for puzzle_mode_controller: button latency, handshake counts, solving, win timing, saturation.
module tb_puzzle_mode_controller;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFail;

  puzzle_mode_controller_if #(.MOVE_W(8)) bus ();

  puzzle_mode_controller #(
    .SCRAMBLE_MOVES(31),
    .WIN_CYCLES(100),
    .MOVE_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic doReset();
    rst_n            = 1'b0;
    bus.scramble_btn = 1'b0;
    bus.rand_ack     = 1'b0;
    bus.solved       = 1'b0;
    bus.move_valid   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presses the button at a negedge and runs runCycles cycles; ack every ackPeriod-th cycle (0 = never).
  task automatic runScramble(input int ackPeriod, input int holdCycles, input int runCycles,
                             output int reqCycles, output int acks, output int firstReq);
    reqCycles = 0;
    acks      = 0;
    firstReq  = -1;
    bus.scramble_btn = 1'b1;
    for (int c = 0; c < runCycles; c++) begin
      if (c == holdCycles) bus.scramble_btn = 1'b0;
      bus.rand_ack = (ackPeriod > 0) && ((c % ackPeriod) == (ackPeriod - 1));
      if (bus.rand_req) begin
        reqCycles++;
        if (bus.rand_ack) acks++;
      end
      @(negedge clk);
      if (bus.rand_req && firstReq < 0) firstReq = c + 1;
    end
    bus.scramble_btn = 1'b0;
    bus.rand_ack     = 1'b0;
  endtask

  task automatic test_reset();
    int r, a, f;
    bit sawReq;
    doReset();
    nChecks++; if (bus.rand_req !== 1'b0) begin nFail++; $display("FAIL rst_req: got %b expected 0", bus.rand_req); end
    nChecks++; if (bus.mix_state !== 1'b0) begin nFail++; $display("FAIL rst_mix: got %b expected 0", bus.mix_state); end
    nChecks++; if (bus.win !== 1'b0) begin nFail++; $display("FAIL rst_win: got %b expected 0", bus.win); end
    nChecks++; if (bus.move_count !== 8'd0) begin nFail++; $display("FAIL rst_count: got %0d expected 0", bus.move_count); end
    // reach SCRAMBLE with count 10, then reset asynchronously between edges
    runScramble(0, 3, 6, r, a, f);
    bus.rand_ack = 1'b1;
    repeat (10) @(negedge clk);
    bus.rand_ack = 1'b0;
    nChecks++; if (bus.scramble_busy !== 1'b1) begin nFail++; $display("FAIL mid_busy: got %b expected 1", bus.scramble_busy); end
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if ({bus.rand_req, bus.mix_state, bus.buzz_en, bus.scramble_busy, bus.win} !== 5'b0)
      begin nFail++; $display("FAIL async_rst_outs: got %b expected 00000",
        {bus.rand_req, bus.mix_state, bus.buzz_en, bus.scramble_busy, bus.win}); end
    @(negedge clk);
    rst_n = 1'b1;
    sawReq = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rand_req || bus.scramble_busy) sawReq = 1'b1;
    end
    nChecks++; if (sawReq !== 1'b0) begin nFail++; $display("FAIL post_rst_idle: got req/busy %b expected 0", sawReq); end
  endtask

  task automatic test_scramble_handshake();
    int r, a, f;
    doReset();
    runScramble(1, 3, 60, r, a, f);
    nChecks++; if (r != 31) begin nFail++; $display("FAIL ack_high_req_cycles: got %0d expected 31", r); end
    nChecks++; if ({bus.mix_state, bus.buzz_en} !== 2'b11) begin nFail++; $display("FAIL solve_outs: got %b expected 11", {bus.mix_state, bus.buzz_en}); end
    nChecks++; if (bus.move_count !== 8'd0) begin nFail++; $display("FAIL solve_count: got %0d expected 0", bus.move_count); end
    doReset();
    runScramble(3, 3, 150, r, a, f);
    nChecks++; if (a != 31) begin nFail++; $display("FAIL ack3_acks: got %0d expected 31", a); end
    nChecks++; if (r != 93) begin nFail++; $display("FAIL ack3_req_cycles: got %0d expected 93", r); end
    nChecks++; if (bus.mix_state !== 1'b1) begin nFail++; $display("FAIL ack3_mix: got %b expected 1", bus.mix_state); end
  endtask

  task automatic test_button_edge();
    int r, a, f, hs;
    doReset();
    runScramble(1, 1000, 1010, r, a, f);
    nChecks++; if (f != 3) begin nFail++; $display("FAIL first_req_latency: got %0d expected 3", f); end
    nChecks++; if (r != 31) begin nFail++; $display("FAIL held_btn_reqs: got %0d expected 31", r); end
    nChecks++; if (bus.mix_state !== 1'b1) begin nFail++; $display("FAIL held_btn_state: got mix %b expected 1", bus.mix_state); end
    // second press in the middle of a scramble must not restart it
    doReset();
    runScramble(0, 3, 6, r, a, f);
    bus.rand_ack = 1'b1;
    repeat (10) @(negedge clk);
    bus.rand_ack = 1'b0;
    bus.scramble_btn = 1'b1;
    repeat (6) @(negedge clk);
    bus.scramble_btn = 1'b0;
    repeat (2) @(negedge clk);
    bus.rand_ack = 1'b1;
    hs = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.rand_req) hs++;
      @(negedge clk);
      if (bus.mix_state) break;
    end
    bus.rand_ack = 1'b0;
    nChecks++; if (hs != 21) begin nFail++; $display("FAIL press_in_scramble_remaining: got %0d expected 21", hs); end
    nChecks++; if (bus.mix_state !== 1'b1) begin nFail++; $display("FAIL press_in_scramble_done: got mix %b expected 1", bus.mix_state); end
  endtask

  task automatic test_solve_count();
    int winCycles;
    bit sawReq;
    // continues from SOLVE with move_count 0
    for (int i = 0; i < 5; i++) begin
      bus.move_valid = 1'b1;
      @(negedge clk);
      bus.move_valid = 1'b0;
      @(negedge clk);
    end
    nChecks++; if (bus.move_count !== 8'd5) begin nFail++; $display("FAIL five_moves: got %0d expected 5", bus.move_count); end
    bus.move_valid = 1'b1;
    bus.solved     = 1'b1;
    @(negedge clk);
    bus.move_valid = 1'b0;
    bus.solved     = 1'b0;
    nChecks++; if (bus.move_count !== 8'd6) begin nFail++; $display("FAIL solve_with_move: got %0d expected 6", bus.move_count); end
    nChecks++; if ({bus.win, bus.mix_state, bus.buzz_en} !== 3'b100) begin nFail++; $display("FAIL win_outs: got %b expected 100", {bus.win, bus.mix_state, bus.buzz_en}); end
    winCycles = 0;
    for (int c = 0; c < 200; c++) begin
      if (!bus.win) break;
      winCycles++;
      bus.move_valid   = (c % 2 == 0);
      bus.scramble_btn = (c >= 10 && c < 20);
      @(negedge clk);
    end
    bus.move_valid   = 1'b0;
    bus.scramble_btn = 1'b0;
    nChecks++; if (winCycles != 100) begin nFail++; $display("FAIL win_duration: got %0d expected 100", winCycles); end
    nChecks++; if (bus.move_count !== 8'd6) begin nFail++; $display("FAIL idle_count_held: got %0d expected 6", bus.move_count); end
    sawReq = 1'b0;
    repeat (6) begin
      if (bus.rand_req || bus.scramble_busy || bus.mix_state) sawReq = 1'b1;
      @(negedge clk);
    end
    nChecks++; if (sawReq !== 1'b0) begin nFail++; $display("FAIL idle_after_win: got active %b expected 0", sawReq); end
  endtask

  task automatic test_saturation();
    int r, a, f;
    doReset();
    runScramble(1, 3, 40, r, a, f);
    bus.move_valid = 1'b1;
    repeat (300) @(negedge clk);
    bus.move_valid = 1'b0;
    @(negedge clk);
    nChecks++; if (bus.move_count !== 8'd255) begin nFail++; $display("FAIL saturate: got %0d expected 255", bus.move_count); end
  endtask

  task automatic test_rescramble();
    int r, a, f;
    bit sawReq;
    // continues from SOLVE with move_count 255
    runScramble(1, 3, 40, r, a, f);
    nChecks++; if (r != 31) begin nFail++; $display("FAIL rescramble_reqs: got %0d expected 31", r); end
    nChecks++; if (f != 3) begin nFail++; $display("FAIL rescramble_latency: got %0d expected 3", f); end
    nChecks++; if (bus.move_count !== 8'd0) begin nFail++; $display("FAIL rescramble_count: got %0d expected 0", bus.move_count); end
    nChecks++; if (bus.mix_state !== 1'b1) begin nFail++; $display("FAIL rescramble_solve: got mix %b expected 1", bus.mix_state); end
    // button event and solved arrive in the same cycle
    bus.scramble_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.solved = 1'b1;
    @(negedge clk);
    bus.solved = 1'b0;
    nChecks++; if ({bus.win, bus.rand_req, bus.scramble_busy} !== 3'b100) begin nFail++; $display("FAIL simul_outs: got %b expected 100", {bus.win, bus.rand_req, bus.scramble_busy}); end
    sawReq = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rand_req) sawReq = 1'b1;
    end
    bus.scramble_btn = 1'b0;
    nChecks++; if (sawReq !== 1'b0) begin nFail++; $display("FAIL simul_no_req: got %b expected 0", sawReq); end
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    test_reset();
    test_scramble_handshake();
    test_button_edge();
    test_solve_count();
    test_saturation();
    test_rescramble();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
